// File: rtl/branch_resolve_predict.sv
// Execute-stage branch resolver with a DEPTH-entry 2-bit saturating-counter predictor
// that self-initialises after reset. Define BRP_STATS_EN for branch/mispredict counters.
module branch_resolve_predict #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_fetch_pc,
  output logic             o_predict,
  output logic             o_ready,
  input  logic             i_valid,
  input  logic [31:0]      i_pc,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic [2:0]       i_branch,
  input  logic             i_pred_taken,
  output logic             o_resolve_valid,
  output logic             o_taken,
  output logic             o_mispredict
`ifdef BRP_STATS_EN
  ,
  output logic [31:0]      o_branch_cnt,
  output logic [31:0]      o_miss_cnt
`endif
);
  localparam int IDX = $clog2(DEPTH);
  localparam logic [IDX-1:0] LAST_IDX = IDX'(DEPTH - 1);
  localparam logic [IDX-1:0] ONE_IDX  = IDX'(1);

  typedef enum logic [0:0] { INIT = 1'b0, RUN = 1'b1 } state_t;

  state_t         state_r;
  logic [IDX-1:0] sweep_r;
  logic [1:0]     table_r [DEPTH];
  logic           ready_r;
  logic           resolve_valid_r;
  logic           taken_r;
  logic           mispredict_r;

  logic [IDX-1:0] fetch_idx_s;
  logic [IDX-1:0] res_idx_s;
  logic [IDX-1:0] wr_idx_s;
  logic [1:0]     cur_ctr_s;
  logic [1:0]     next_ctr_s;
  logic [1:0]     wr_data_s;
  logic           zero_s;
  logic           neg_s;
  logic           cond_s;
  logic           active_s;
  logic           resolve_s;
  logic           miss_s;
  logic           wr_en_s;
  logic           unused_s;

  assign fetch_idx_s = i_fetch_pc[IDX+1:2];
  assign res_idx_s   = i_pc[IDX+1:2];
  assign unused_s    = ^{i_fetch_pc[31:IDX+2], i_fetch_pc[1:0], i_pc[31:IDX+2], i_pc[1:0]};

  assign zero_s    = (i_data1 == {WIDTH{1'b0}});
  assign neg_s     = i_data1[WIDTH-1];
  assign resolve_s = ready_r & i_valid;
  assign cur_ctr_s = table_r[res_idx_s];
  assign miss_s    = cond_s ^ i_pred_taken;

  // Lookup is a plain read of registered state, so a same-cycle update is not visible yet.
  assign o_predict       = ready_r & table_r[fetch_idx_s][1];
  assign o_ready         = ready_r;
  assign o_resolve_valid = resolve_valid_r;
  assign o_taken         = taken_r;
  assign o_mispredict    = mispredict_r;

  // Branch condition decode; magnitude tests use sign bit and zero detect (signed compare to 0)
  always_comb begin
    cond_s   = 1'b0;
    active_s = 1'b1;
    case (i_branch)
      3'b001:  cond_s = (i_data1 == i_data2);
      3'b010:  cond_s = (i_data1 != i_data2);
      3'b011:  cond_s = neg_s | zero_s;
      3'b100:  cond_s = ~neg_s & ~zero_s;
      3'b101:  cond_s = neg_s;
      3'b110:  cond_s = ~neg_s;
      default: begin
        cond_s   = 1'b0;
        active_s = 1'b0;
      end
    endcase
  end

  // Saturating counter step for the resolved entry
  always_comb begin
    next_ctr_s = cur_ctr_s;
    if (cond_s) begin
      if (cur_ctr_s != 2'b11) next_ctr_s = cur_ctr_s + 2'b01;
      else                    next_ctr_s = cur_ctr_s;
    end else begin
      if (cur_ctr_s != 2'b00) next_ctr_s = cur_ctr_s - 2'b01;
      else                    next_ctr_s = cur_ctr_s;
    end
  end

  // Single table write port shared by the init sweep and resolution updates
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = sweep_r;
    wr_data_s = 2'b01;
    if (i_rst) begin
      wr_en_s = 1'b0;
    end else if (state_r == INIT) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = sweep_r;
      wr_data_s = 2'b01;
    end else if (resolve_s && active_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = res_idx_s;
      wr_data_s = next_ctr_s;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Counter table storage; contents only become meaningful once the sweep finishes
  always_ff @(posedge i_clk) begin
    if (wr_en_s) table_r[wr_idx_s] <= wr_data_s;
  end

  // INIT/RUN control and registered resolution outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r         <= INIT;
      sweep_r         <= {IDX{1'b0}};
      ready_r         <= 1'b0;
      resolve_valid_r <= 1'b0;
      taken_r         <= 1'b0;
      mispredict_r    <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          sweep_r <= sweep_r + ONE_IDX;
          if (sweep_r == LAST_IDX) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= INIT;
            ready_r <= 1'b0;
          end
        end
        RUN: begin
          state_r <= RUN;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= INIT;
          sweep_r <= {IDX{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
      resolve_valid_r <= resolve_s;
      taken_r         <= resolve_s & cond_s;
      mispredict_r    <= resolve_s & miss_s;
    end
  end

`ifdef BRP_STATS_EN
  logic [31:0] branch_cnt_r;
  logic [31:0] miss_cnt_r;

  // Saturating branch and mispredict statistics
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      branch_cnt_r <= 32'h0000_0000;
      miss_cnt_r   <= 32'h0000_0000;
    end else begin
      if (resolve_s && active_s && (branch_cnt_r != 32'hFFFF_FFFF))
        branch_cnt_r <= branch_cnt_r + 32'h0000_0001;
      if (resolve_s && miss_s && (miss_cnt_r != 32'hFFFF_FFFF))
        miss_cnt_r <= miss_cnt_r + 32'h0000_0001;
    end
  end

  assign o_branch_cnt = branch_cnt_r;
  assign o_miss_cnt   = miss_cnt_r;
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Self-checking bench for branch_resolve_predict: directed scenarios plus random traffic
// against an array-based reference model. Honors BRP_STATS_EN when defined.
module tb_branch_resolve_predict;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic [31:0]      i_fetch_pc = 32'h0;
  logic             o_predict;
  logic             o_ready;
  logic             i_valid = 1'b0;
  logic [31:0]      i_pc = 32'h0;
  logic [WIDTH-1:0] i_data1 = '0;
  logic [WIDTH-1:0] i_data2 = '0;
  logic [2:0]       i_branch = 3'b000;
  logic             i_pred_taken = 1'b0;
  logic             o_resolve_valid;
  logic             o_taken;
  logic             o_mispredict;
`ifdef BRP_STATS_EN
  logic [31:0]      o_branch_cnt;
  logic [31:0]      o_miss_cnt;
`endif

  branch_resolve_predict #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fetch_pc(i_fetch_pc), .o_predict(o_predict),
    .o_ready(o_ready), .i_valid(i_valid), .i_pc(i_pc), .i_data1(i_data1),
    .i_data2(i_data2), .i_branch(i_branch), .i_pred_taken(i_pred_taken),
    .o_resolve_valid(o_resolve_valid), .o_taken(o_taken), .o_mispredict(o_mispredict)
`ifdef BRP_STATS_EN
    , .o_branch_cnt(o_branch_cnt), .o_miss_cnt(o_miss_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model: remaining sweep cycles (0 = running), counters, statistics
  int      init_left;
  int      ctr [DEPTH];
  longint  m_bcnt;
  longint  m_mcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (br)
      3'd1: return sa == sb;
      3'd2: return sa != sb;
      3'd3: return sa <= 0;
      3'd4: return sa > 0;
      3'd5: return sa < 0;
      3'd6: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rdata();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rpc();
    return ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // One clock: drive inputs, check lookup/ready before the edge, then registered results after it.
  task automatic step(input bit rst, input bit valid, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] br, input bit pred, input logic [31:0] fpc);
    bit e_rv;
    bit e_t;
    bit e_m;
    int fidx;
    int ridx;
    i_rst = rst; i_valid = valid; i_pc = pc; i_data1 = a; i_data2 = b;
    i_branch = br; i_pred_taken = pred; i_fetch_pc = fpc;
    #2;
    fidx = int'((fpc >> 2) % 32'(DEPTH));
    ridx = int'((pc >> 2) % 32'(DEPTH));
    chk("ready", o_ready, init_left == 0);
    chk("predict", o_predict, (init_left == 0) ? (ctr[fidx] >= 2) : 1'b0);
    e_rv = 1'b0; e_t = 1'b0; e_m = 1'b0;
    if (rst) begin
      init_left = DEPTH; m_bcnt = 0; m_mcnt = 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) foreach (ctr[i]) ctr[i] = 1;
    end else if (valid) begin
      e_rv = 1'b1;
      e_t  = ref_taken(br, a, b);
      e_m  = e_t ^ pred;
      if (br != 3'd0 && br != 3'd7) begin
        ctr[ridx] = e_t ? ((ctr[ridx] < 3) ? ctr[ridx] + 1 : 3) : ((ctr[ridx] > 0) ? ctr[ridx] - 1 : 0);
        if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
      end
      if (e_m && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
    end
    @(posedge i_clk);
    #1;
    chk("resolve_valid", o_resolve_valid, e_rv);
    chk("taken", o_taken, e_t);
    chk("mispredict", o_mispredict, e_m);
`ifdef BRP_STATS_EN
    chk("branch_cnt", o_branch_cnt, m_bcnt);
    chk("miss_cnt", o_miss_cnt, m_mcnt);
`endif
  endtask

  task automatic idle_rand();
    step(1'b0, 1'($urandom_range(0, 1)), rpc(), rdata(), rdata(), 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), rpc());
  endtask

  task automatic measure_init(input string tag);
    int lowcnt;
    lowcnt = 0;
    for (int k = 0; k < 200 && o_ready !== 1'b1; k++) begin
      lowcnt++;
      idle_rand();
    end
    chk(tag, lowcnt, DEPTH);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] pc;
    logic [31:0] fpc;

    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    init_left = DEPTH; m_bcnt = 0; m_mcnt = 0;
    foreach (ctr[i]) ctr[i] = 0;
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_resolve_valid", o_resolve_valid, 1'b0);
    chk("rst_taken", o_taken, 1'b0);
    chk("rst_mispredict", o_mispredict, 1'b0);

    measure_init("init_len");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'(i) << 2);

    // beq equal operands, predicted not taken, twice at 0x40
    step(1'b0, 1'b1, 32'h40, 32'h5, 32'h5, 3'b001, 1'b0, 32'h40);
    chk("beq_taken", o_taken, 1'b1);
    chk("beq_mispredict", o_mispredict, 1'b1);
    step(1'b0, 1'b1, 32'h40, 32'h5, 32'h5, 3'b001, 1'b0, 32'h40);
    chk("beq_predict_after", o_predict, 1'b1);

    // signed sign-bit checks
    step(1'b0, 1'b1, 32'h100, 32'h8000_0000, 32'h0, 3'b101, 1'b1, 32'h0);
    chk("bltz_taken", o_taken, 1'b1);
    chk("bltz_mispredict", o_mispredict, 1'b0);
    step(1'b0, 1'b1, 32'h100, 32'h8000_0000, 32'h0, 3'b100, 1'b0, 32'h0);
    chk("bgtz_taken", o_taken, 1'b0);

    // same-cycle lookup and update of entry 32 (01 -> 10)
    step(1'b0, 1'b1, 32'h80, 32'h7, 32'h7, 3'b001, 1'b0, 32'h80);
    chk("bypass_next", o_predict, 1'b1);

    // four not-taken bne saturate at 00, then reserved code leaves the table alone
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hC0, 32'h3, 32'h3, 3'b010, 1'b0, 32'hC0);
    step(1'b0, 1'b1, 32'hC0, 32'h3, 32'h9, 3'b111, 1'b1, 32'hC0);
    chk("reserved_taken", o_taken, 1'b0);
    chk("reserved_mispredict", o_mispredict, 1'b1);
    step(1'b0, 1'b1, 32'hC0, 32'h3, 32'h3, 3'b001, 1'b0, 32'hC0);
    step(1'b0, 1'b0, 32'hC0, 32'h0, 32'h0, 3'b000, 1'b0, 32'hC0);

    // random traffic over a few table entries
    for (int i = 0; i < 400; i++) begin
      a   = rdata();
      pc  = rpc();
      fpc = ($urandom_range(0, 3) == 0) ? pc : rpc();
      step(1'b0, 1'($urandom_range(0, 3) != 0), pc, a, ($urandom_range(0, 1) == 1) ? a : rdata(),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), fpc);
    end

    // reset during RUN with a valid resolve in flight
    step(1'b1, 1'b1, 32'h40, 32'h5, 32'h5, 3'b001, 1'b0, 32'h40);
    chk("rst_run_resolve_valid", o_resolve_valid, 1'b0);
    chk("rst_run_ready", o_ready, 1'b0);
`ifdef BRP_STATS_EN
    chk("rst_run_branch_cnt", o_branch_cnt, 32'h0);
    chk("rst_run_miss_cnt", o_miss_cnt, 32'h0);
`endif
    measure_init("reinit_len");

    // reset in the middle of the sweep restarts it
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) idle_rand();
    step(1'b1, 1'b1, 32'h40, 32'h1, 32'h1, 3'b001, 1'b1, 32'h40);
    measure_init("midsweep_len");
    for (int i = 0; i < 100; i++) begin
      a = rdata();
      step(1'b0, 1'b1, rpc(), a, ($urandom_range(0, 1) == 1) ? a : rdata(),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rpc());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_predict.md
BRANCH_RESOLVE_PREDICT -- requirements
Module: branch_resolve_predict

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter DEPTH, default 64, prediction table entries; power of two, at least 4; IDX = log2(DEPTH).
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_fetch_pc  input  32  fetch-stage PC for lookup; index = i_fetch_pc[IDX+1:2].
REQ-006 o_predict  output  1  predicted taken for i_fetch_pc; combinational from table.
REQ-007 o_ready  output  1  high when table initialisation is complete.
REQ-008 i_valid  input  1  resolve request, execute stage.
REQ-009 i_pc  input  32  PC of the branch being resolved; index = i_pc[IDX+1:2].
REQ-010 i_data1, i_data2  input  WIDTH  operands, two's complement.
REQ-011 i_branch  input  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved.
REQ-012 i_pred_taken  input  1  prediction that fetch used for this branch.
REQ-013 o_resolve_valid, o_taken, o_mispredict  output  1 each  registered resolution result.

Function
REQ-014 Comparisons SHALL be signed, over the full WIDTH bits.
REQ-015 beq: data1 == data2. bne: data1 != data2. blez: data1 <= 0. bgtz: data1 > 0. bltz: data1 < 0. bgez: data1 >= 0. The blez, bgtz, bltz and bgez codes ignore i_data2.
REQ-016 Codes 000 and 111 SHALL give taken = 0 and SHALL NOT update the table.
REQ-017 Resolution latency SHALL be 1 cycle. If i_valid is high at edge N, then o_resolve_valid is 1 after edge N, with o_taken and o_mispredict = taken XOR i_pred_taken.
REQ-018 If i_valid is low, o_resolve_valid SHALL be 0 after the edge, and o_taken and o_mispredict SHALL be 0.
REQ-019 Table: DEPTH 2-bit saturating counters. Prediction = counter[1].
REQ-020 Update at the same edge as REQ-017 for codes 001 to 110: taken increments the counter, saturating at 11; not taken decrements it, saturating at 00.
REQ-021 If lookup and update hit the same index in the same cycle, o_predict SHALL return the pre-update value.
REQ-022 FSM states: INIT and RUN.
REQ-023 INIT: a sweep counter writes 01 to entry k at cycle k, for k = 0..DEPTH-1, then moves to RUN. Duration is exactly DEPTH cycles after reset deasserts.
REQ-024 In INIT: o_ready = 0, o_predict = 0, i_valid ignored (o_resolve_valid stays 0, no updates).
REQ-025 RUN: o_ready = 1. Remains in RUN until i_rst.

Reset
REQ-026 i_rst high at an edge SHALL enter INIT with sweep counter = 0 and o_resolve_valid, o_taken, o_mispredict = 0.
REQ-027 Reset mid-sweep or mid-RUN SHALL restart the full DEPTH-cycle sweep. Any in-flight resolution is discarded.
REQ-028 Table contents are undefined until the sweep completes. No output exposes them before o_ready is high.

Configuration
REQ-029 Macro BRP_STATS_EN.
REQ-030 With the macro defined: outputs o_branch_cnt and o_miss_cnt, 32 bits each, are present.
REQ-031 o_branch_cnt increments on every resolution with code 001 to 110.
REQ-032 o_miss_cnt increments on every o_mispredict.
REQ-033 Both counters saturate at 0xFFFFFFFF and clear on i_rst.
REQ-034 Without the macro: the counters and ports are absent, and all other behaviour is identical.

Verification
REQ-035 Reset, then DEPTH=64: o_ready = 0 for exactly 64 cycles, then 1. o_predict = 0 at every PC after init.
REQ-036 beq, data1 = data2 = 0x5, pred 0, at PC 0x40: next cycle taken = 1, mispredict = 1. A second identical branch moves entry 16 from 10 to 11, and o_predict at 0x40 = 1.
REQ-037 bltz, data1 = 0x80000000, pred 1: taken = 1, mispredict = 0. bgtz with the same data1: taken = 0 (signed check).
REQ-038 Same cycle: fetch 0x40 and resolve 0x40 with a counter at 01 that goes to 10. o_predict that cycle = 0, next cycle = 1.
REQ-039 Four not-taken bne (equal operands) on a counter at 01: the counter holds at 00 with no underflow. Code 111 with pred 1: mispredict = 1, no table change.
REQ-040 Assert i_rst during RUN with i_valid high: o_resolve_valid = 0 next cycle, and the full 64-cycle sweep repeats. With BRP_STATS_EN, both counters read 0.
